// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: shared widths, types and the lower-part-OR approximate add function
package approx_adder_pkg;
  localparam int OP_W = 12;
  localparam int SUM_W = OP_W + 1;
  localparam int MAX_W = 64;
  typedef logic [OP_W-1:0] operand_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [MAX_W:0] wide_t;
  // Low l bits are OR-ed; bit l-1 of both operands predicts the carry into the exact upper part.
  function automatic wide_t lor_add(input wide_t a, input wide_t b, input int l);
    wide_t m, c;
    m = (wide_t'(1) << l) - wide_t'(1);
    c = (l > 0) ? (((a & b) >> (l - 1)) & wide_t'(1)) : '0;
    return (((a >> l) + (b >> l) + c) << l) | ((a | b) & m);
  endfunction
endpackage

// File: rtl/approx_add_core.sv
// approx_add_core: stage-0 exact / lower-part-OR sum select, plus the shadow exact sum
module approx_add_core import approx_adder_pkg::*; #(
  parameter int WIDTH = OP_W,
  parameter int APPROX_LSB = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_approx,
  output logic [WIDTH:0]   o_sum,
  output logic [WIDTH:0]   o_exact
);
  logic [MAX_W-WIDTH-1:0] w_unused_hi;
  logic [WIDTH:0] w_lor;
  // operands are zero-extended, so only the low WIDTH+1 bits of the wide result carry information
  always_comb begin
    {w_unused_hi, w_lor} = lor_add(wide_t'(i_a), wide_t'(i_b), APPROX_LSB);
    o_exact = {1'b0, i_a} + {1'b0, i_b};
    o_sum = i_approx ? w_lor : o_exact;
  end
endmodule

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: elastic pipelined approximate adder; APPROX_ADDER_ERR_MON_EN adds an error monitor
module approx_adder_pipe import approx_adder_pkg::*; #(
  parameter int WIDTH = OP_W,
  parameter int APPROX_LSB = 4,
  parameter int STAGES = 2
`ifdef APPROX_ADDER_ERR_MON_EN
  , parameter int ERR_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_approx,
  output logic             busy
`ifdef APPROX_ADDER_ERR_MON_EN
  ,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH:0]   err_max
`endif
);
  localparam int SW = WIDTH + 1;
  logic [SW-1:0] w_sum0, w_ex0;
  logic [STAGES-1:0] w_v, w_tag;
  logic [SW-1:0] w_sum [STAGES];
  logic [STAGES:0] w_adv;

  approx_add_core #(.WIDTH(WIDTH), .APPROX_LSB(APPROX_LSB)) u_core (
    .i_a(in_a),
    .i_b(in_b),
    .i_approx(in_approx),
    .o_sum(w_sum0),
    .o_exact(w_ex0)
  );

  // back-propagated advance: a slice may load when it is empty or its successor moves on
  always_comb begin
    w_adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) w_adv[k] = !w_v[k] | w_adv[k+1];
  end

`ifdef APPROX_ADDER_ERR_MON_EN
  logic [SW-1:0] w_ex [STAGES];
`else
  logic [SW-1:0] w_unused_ex;
  assign w_unused_ex = w_ex0;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic r_v, r_tag;
    logic [SW-1:0] r_sum;
    logic w_vi, w_ti;
    logic [SW-1:0] w_si;
    if (i == 0) begin : g_in
      assign w_vi = in_valid;
      assign w_ti = in_approx;
      assign w_si = w_sum0;
    end else begin : g_in
      assign w_vi = w_v[i-1];
      assign w_ti = w_tag[i-1];
      assign w_si = w_sum[i-1];
    end
    // elastic slice: take the upstream item on advance, otherwise hold data stable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_tag <= 1'b0;
        r_sum <= '0;
      end else if (w_adv[i]) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_tag <= w_ti;
          r_sum <= w_si;
        end
      end
    end
    assign w_v[i] = r_v;
    assign w_tag[i] = r_tag;
    assign w_sum[i] = r_sum;
`ifdef APPROX_ADDER_ERR_MON_EN
    logic [SW-1:0] r_ex, w_ei;
    if (i == 0) begin : g_ex
      assign w_ei = w_ex0;
    end else begin : g_ex
      assign w_ei = w_ex[i-1];
    end
    // shadow exact sum travels with its transaction under the same advance rule
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ex <= '0;
      else if (w_adv[i] && w_vi) r_ex <= w_ei;
    end
    assign w_ex[i] = r_ex;
`endif
  end

  assign in_ready = w_adv[0];
  assign out_valid = w_v[STAGES-1];
  assign out_sum = w_sum[STAGES-1];
  assign out_approx = w_tag[STAGES-1];
  assign busy = |w_v;

`ifdef APPROX_ADDER_ERR_MON_EN
  logic [ERR_W-1:0] r_err_cnt;
  logic [SW-1:0] r_err_max, w_diff, w_ex_out;
  logic w_err;
  assign w_ex_out = w_ex[STAGES-1];
  assign w_err = out_valid & out_ready & out_approx & (out_sum != w_ex_out);
  assign w_diff = (out_sum > w_ex_out) ? out_sum - w_ex_out : w_ex_out - out_sum;
  // error statistics; a clear wins over a coincident error event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (w_err) begin
      r_err_cnt <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
      r_err_max <= (w_diff > r_err_max) ? w_diff : r_err_max;
    end
  end
  assign err_cnt = r_err_cnt;
  assign err_max = r_err_max;
`endif
endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: randomized scoreboard bench for approx_adder_pipe
module tb_approx_adder_pipe;
  localparam int W = 12;
  localparam int S = 2;
  localparam int EW = 4;
  typedef logic [W:0] sum_t;
  typedef struct {
    sum_t sum;
    sum_t ex;
    logic tag;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_approx, out_valid, out_ready, out_approx, busy;
  logic [W-1:0] in_a, in_b;
  sum_t out_sum;
`ifdef APPROX_ADDER_ERR_MON_EN
  logic err_clr;
  logic [EW-1:0] err_cnt;
  sum_t err_max;
`endif

  always #5 clk = ~clk;

  approx_adder_pipe #(
    .WIDTH(W),
    .APPROX_LSB(4),
    .STAGES(S)
`ifdef APPROX_ADDER_ERR_MON_EN
    , .ERR_W(EW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_approx(in_approx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_approx(out_approx),
    .busy(busy)
`ifdef APPROX_ADDER_ERR_MON_EN
    ,
    .err_clr(err_clr),
    .err_cnt(err_cnt),
    .err_max(err_max)
`endif
  );

  exp_t q[$];
  int n_run = 0, n_fail = 0, cyc = 0, m_cnt = 0, m_max = 0;
  bit stalled = 0, chk_lat = 0, acc = 0;
  sum_t hold_sum;
  logic hold_tag;

  // exact: plain integer add; approximate: exact add of the upper parts with the
  // predicted carry (bit 3 of both operands) worth 16, OR-ed low nibble on top
  function automatic sum_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (!ap) return sum_t'(ia + ib);
    return sum_t'(((ia & ~15) + (ib & ~15) + ((ia & ib & 8) << 1)) | ((ia | ib) & 15));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: settle, score transfers, advance past the edge
  task automatic cycle();
    exp_t e;
    int d;
    #1;
    if (stalled) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(out_sum), 32'(hold_sum));
      chk("stall_tag", 32'(out_approx), 32'(hold_tag));
    end
    acc = in_valid && in_ready;
`ifdef APPROX_ADDER_ERR_MON_EN
    if (err_clr) begin
      m_cnt = 0;
      m_max = 0;
    end
`endif
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("sum", 32'(out_sum), 32'(e.sum));
        chk("tag", 32'(out_approx), 32'(e.tag));
        if (chk_lat) chk("latency", cyc - e.t, S);
`ifdef APPROX_ADDER_ERR_MON_EN
        if (!err_clr && e.tag && e.sum != e.ex) begin
          if (m_cnt < 2 ** EW - 1) m_cnt++;
          d = int'(e.sum) - int'(e.ex);
          if (d < 0) d = -d;
          if (d > m_max) m_max = d;
        end
`endif
      end
    end
    if (acc) q.push_back('{ref_add(in_a, in_b, in_approx), ref_add(in_a, in_b, 1'b0), in_approx, cyc});
    stalled = out_valid && !out_ready;
    hold_sum = out_sum;
    hold_tag = out_approx;
    @(posedge clk);
    cyc++;
    #1;
`ifdef APPROX_ADDER_ERR_MON_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("err_max", 32'(err_max), 32'(m_max));
`endif
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
    in_a = a;
    in_b = b;
    in_approx = ap;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) cycle();
    if (!acc) chk("put_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic [3:0] pat;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_approx = 1'b0;
    out_ready = 1'b1;
`ifdef APPROX_ADDER_ERR_MON_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_approx", 32'(out_approx), 32'd0);
`ifdef APPROX_ADDER_ERR_MON_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_err_max", 32'(err_max), 32'd0);
`endif
    rst_n = 1'b1;

    // directed corner operands, unstalled, fixed latency
    chk_lat = 1;
    put(12'h00F, 12'h001, 1'b1);
    drain();
`ifdef APPROX_ADDER_ERR_MON_EN
    chk("t1_err_cnt", 32'(err_cnt), 32'd1);
    chk("t1_err_max", 32'(err_max), 32'd1);
`endif
    put(12'h00F, 12'h001, 1'b0);
    drain();
    put(12'h008, 12'h008, 1'b1);
    drain();
`ifdef APPROX_ADDER_ERR_MON_EN
    chk("t2_err_max", 32'(err_max), 32'd8);
`endif
    put(12'hFFF, 12'hFFF, 1'b1);
    put(12'hFFF, 12'hFFF, 1'b0);
    drain();

    // alternating modes with out_ready pattern 1-0-0-1
    chk_lat = 0;
    pat = 4'b1001;
    n = 0;
    k = 0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_valid = 1'b1;
    while (n < 20 && k < 200) begin
      in_approx = n[0];
      out_ready = pat[k % 4];
      cycle();
      k++;
      if (acc) begin
        n++;
        in_a = W'($urandom);
        in_b = W'($urandom);
      end
    end
    chk("t4_accepted", n, 20);
    in_valid = 1'b0;
    drain();

    // random traffic, random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_approx = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    put(W'($urandom), W'($urandom), 1'b1);
    put(W'($urandom), W'($urandom), 1'b0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    q.delete();
    stalled = 0;
    m_cnt = 0;
    m_max = 0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) cycle();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

`ifdef APPROX_ADDER_ERR_MON_EN
    // clear coinciding with an erroneous output
    put(12'h00F, 12'h001, 1'b1);
    drain();
    out_ready = 1'b0;
    put(12'h008, 12'h008, 1'b1);
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    err_clr = 1'b1;
    out_ready = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("t6_clr_cnt", 32'(err_cnt), 32'd0);
    chk("t6_clr_max", 32'(err_max), 32'd0);
    // saturation
    in_a = 12'h00F;
    in_b = 12'h001;
    in_approx = 1'b1;
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 2 ** EW + 3; i++) begin
      cycle();
      if (acc) n++;
    end
    in_valid = 1'b0;
    drain();
    chk("t6_sat_cnt", 32'(err_cnt), 32'(2 ** EW - 1));
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
